// File: rtl/lcd12864_ctrl.sv
// LCD12864 refresh controller: runs the power-up wait and init sequence, then
// streams a 64-character buffer to a byte-level driver, one line at a time.
module lcd12864_ctrl #(
    parameter int CLK_FRE   = 50,
    parameter int PWRUP_MS  = 40,
    parameter int ACC_TO_MS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [5:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic       send_en,
    output logic [7:0] send_data,
    output logic       send_rs,
    output logic       send_rw,
    input  logic       send_busy,
    output logic       init_done,
    output logic       frame_done,
    output logic       err
);

    localparam int unsigned PWRUP_CYC = CLK_FRE * 1000 * PWRUP_MS;
    localparam int unsigned ACC_CYC   = CLK_FRE * 1000 * ACC_TO_MS;
    localparam int unsigned MAX_CYC   = (PWRUP_CYC > ACC_CYC) ? PWRUP_CYC : ACC_CYC;
    localparam int CNT_W              = $clog2(MAX_CYC) + 1;
    localparam logic [CNT_W-1:0] PWRUP_LAST = CNT_W'(PWRUP_CYC - 1);
    localparam logic [CNT_W-1:0] ACC_LAST   = CNT_W'(ACC_CYC - 1);

    typedef enum logic [2:0] {
        PWRUP,
        ISSUE,
        ACCEPT,
        COMPLETE,
        NEXT
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    // Sequence pointer: init step while init_phase is set, otherwise line/column
    // with line_cmd marking that the line-address command is still pending.
    logic       init_phase_reg, init_phase_next;
    logic [1:0] init_idx_reg, init_idx_next;
    logic [1:0] line_reg, line_next;
    logic [3:0] col_reg, col_next;
    logic       line_cmd_reg, line_cmd_next;

    logic       send_en_reg, send_en_next;
    logic [7:0] send_data_reg, send_data_next;
    logic       send_rs_reg, send_rs_next;
    logic       init_done_reg, init_done_next;
    logic       frame_done_reg, frame_done_next;
    logic       err_reg, err_next;

    logic [7:0] char_mem [64];
    logic [7:0] xfer_data;
    logic       xfer_rs;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) begin
                char_mem[i] <= 8'h20;
            end
        end else if (wr_en) begin
            char_mem[wr_addr] <= wr_data;
        end
    end

    // Byte addressed by the current pointer; sampled only when entering ISSUE.
    always_comb begin
        xfer_rs   = 1'b0;
        xfer_data = 8'h00;
        if (init_phase_reg) begin
            case (init_idx_reg)
                2'd0:    xfer_data = 8'h30;
                2'd1:    xfer_data = 8'h0C;
                2'd2:    xfer_data = 8'h01;
                default: xfer_data = 8'h06;
            endcase
        end else if (line_cmd_reg) begin
            case (line_reg)
                2'd0:    xfer_data = 8'h80;
                2'd1:    xfer_data = 8'h90;
                2'd2:    xfer_data = 8'h88;
                default: xfer_data = 8'h98;
            endcase
        end else begin
            xfer_rs   = 1'b1;
            xfer_data = char_mem[{line_reg, col_reg}];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= PWRUP;
            cnt_reg        <= '0;
            init_phase_reg <= 1'b1;
            init_idx_reg   <= 2'd0;
            line_reg       <= 2'd0;
            col_reg        <= 4'd0;
            line_cmd_reg   <= 1'b1;
            send_en_reg    <= 1'b0;
            send_data_reg  <= 8'h00;
            send_rs_reg    <= 1'b0;
            init_done_reg  <= 1'b0;
            frame_done_reg <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            init_phase_reg <= init_phase_next;
            init_idx_reg   <= init_idx_next;
            line_reg       <= line_next;
            col_reg        <= col_next;
            line_cmd_reg   <= line_cmd_next;
            send_en_reg    <= send_en_next;
            send_data_reg  <= send_data_next;
            send_rs_reg    <= send_rs_next;
            init_done_reg  <= init_done_next;
            frame_done_reg <= frame_done_next;
            err_reg        <= err_next;
        end
    end

    // Outputs are registered from the next state, so send_en rises on the edge
    // that enters ISSUE and is never high while PWRUP is the current state.
    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        init_phase_next = init_phase_reg;
        init_idx_next   = init_idx_reg;
        line_next       = line_reg;
        col_next        = col_reg;
        line_cmd_next   = line_cmd_reg;
        send_en_next    = send_en_reg;
        send_data_next  = send_data_reg;
        send_rs_next    = send_rs_reg;
        init_done_next  = init_done_reg;
        frame_done_next = 1'b0;
        err_next        = err_reg;

        case (state_reg)
            PWRUP: begin
                send_en_next = 1'b0;
                if (cnt_reg == PWRUP_LAST) begin
                    cnt_next       = '0;
                    state_next     = ISSUE;
                    send_en_next   = 1'b1;
                    send_data_next = xfer_data;
                    send_rs_next   = xfer_rs;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ISSUE: begin
                cnt_next   = '0;
                state_next = ACCEPT;
            end
            ACCEPT: begin
                if (send_busy) begin
                    send_en_next = 1'b0;
                    state_next   = COMPLETE;
                end else if (cnt_reg == ACC_LAST) begin
                    send_en_next    = 1'b0;
                    err_next        = 1'b1;
                    init_done_next  = 1'b0;
                    cnt_next        = '0;
                    init_phase_next = 1'b1;
                    init_idx_next   = 2'd0;
                    line_next       = 2'd0;
                    col_next        = 4'd0;
                    line_cmd_next   = 1'b1;
                    state_next      = PWRUP;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            COMPLETE: begin
                if (!send_busy) begin
                    state_next = NEXT;
                    if (init_phase_reg) begin
                        if (init_idx_reg == 2'd3) begin
                            init_phase_next = 1'b0;
                            init_done_next  = 1'b1;
                            line_next       = 2'd0;
                            col_next        = 4'd0;
                            line_cmd_next   = 1'b1;
                        end else begin
                            init_idx_next = init_idx_reg + 2'd1;
                        end
                    end else if (line_cmd_reg) begin
                        line_cmd_next = 1'b0;
                    end else if (col_reg == 4'd15) begin
                        col_next        = 4'd0;
                        line_cmd_next   = 1'b1;
                        line_next       = line_reg + 2'd1;
                        frame_done_next = (line_reg == 2'd3);
                    end else begin
                        col_next = col_reg + 4'd1;
                    end
                end
            end
            NEXT: begin
                state_next     = ISSUE;
                send_en_next   = 1'b1;
                send_data_next = xfer_data;
                send_rs_next   = xfer_rs;
            end
            default: begin
                state_next   = PWRUP;
                cnt_next     = '0;
                send_en_next = 1'b0;
            end
        endcase
    end

    assign send_en    = send_en_reg;
    assign send_data  = send_data_reg;
    assign send_rs    = send_rs_reg;
    assign send_rw    = 1'b0;
    assign init_done  = init_done_reg;
    assign frame_done = frame_done_reg;
    assign err        = err_reg;

endmodule

// File: tb/tb_lcd12864_ctrl.sv
// Bench for lcd12864_ctrl: a driver model captures every accepted transfer and
// the scenario tasks compare that stream against a scoreboard of expected bytes.
module tb_lcd12864_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [5:0] wr_addr;
    logic [7:0] wr_data;
    logic       send_en;
    logic [7:0] send_data;
    logic       send_rs;
    logic       send_rw;
    logic       send_busy = 1'b0;
    logic       init_done;
    logic       frame_done;
    logic       err;

    int checks   = 0;
    int failures = 0;

    logic [8:0] obs_q [$];
    logic [8:0] exp_q [$];
    logic [7:0] model_mem [64];
    logic [7:0] line_cmd [4];

    bit         drv_mute = 1'b0;
    int         acc_cnt = 0;
    int         busy_cnt = 0;
    int         xfer_total = 0;
    int         fd_count = 0;
    int         fd_at [$];
    int         stab_viol = 0;
    logic       prev_en = 1'b0;
    logic [8:0] prev_x = '0;

    always #5 clk = ~clk;

    lcd12864_ctrl #(
        .CLK_FRE  (1),
        .PWRUP_MS (1),
        .ACC_TO_MS(1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .send_en   (send_en),
        .send_data (send_data),
        .send_rs   (send_rs),
        .send_rw   (send_rw),
        .send_busy (send_busy),
        .init_done (init_done),
        .frame_done(frame_done),
        .err       (err)
    );

    // Driver model: accepts 3 cycles after send_en, then busy for 5 cycles.
    always @(negedge clk) begin
        if (rst) begin
            send_busy  = 1'b0;
            acc_cnt    = 0;
            busy_cnt   = 0;
            prev_en    = 1'b0;
            xfer_total = 0;
            fd_count   = 0;
            fd_at.delete();
            obs_q.delete();
        end else begin
            if (send_en && prev_en && ({send_rs, send_data} !== prev_x)) stab_viol++;
            if (send_rw !== 1'b0) stab_viol++;
            prev_en = send_en;
            prev_x  = {send_rs, send_data};
            if (frame_done === 1'b1) begin
                fd_count++;
                fd_at.push_back(xfer_total);
            end
            if (send_busy) begin
                busy_cnt++;
                if (busy_cnt == 5) send_busy = 1'b0;
            end else if (send_en && !drv_mute) begin
                acc_cnt++;
                if (acc_cnt == 3) begin
                    send_busy = 1'b1;
                    acc_cnt   = 0;
                    busy_cnt  = 0;
                    obs_q.push_back({send_rs, send_data});
                    xfer_total++;
                end
            end
        end
    end

    task automatic get_xfer(output logic [8:0] x, output bit ok);
        int n = 0;
        x  = '0;
        ok = 1'b0;
        while (obs_q.size() == 0 && n < 1500) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (obs_q.size() != 0) begin
            x  = obs_q.pop_front();
            ok = 1'b1;
        end
    endtask

    task automatic do_write(input logic [5:0] a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        model_mem[a] = d;
    endtask

    task automatic push_line(input int l);
        exp_q.push_back({1'b0, line_cmd[l]});
        for (int c = 0; c < 16; c++) exp_q.push_back({1'b1, model_mem[l*16 + c]});
    endtask

    task automatic count_pwrup(input string tag);
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!send_en && n < 1500);
        checks++;
        if (n != 1000) begin
            failures++;
            $display("FAIL %s send_en low cycles got=%0d exp=1000", tag, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks += 7;
        if (send_en !== 1'b0)      begin failures++; $display("FAIL rst_send_en got=%b exp=0", send_en); end
        if (send_data !== 8'h00)   begin failures++; $display("FAIL rst_send_data got=%h exp=00", send_data); end
        if (send_rs !== 1'b0)      begin failures++; $display("FAIL rst_send_rs got=%b exp=0", send_rs); end
        if (send_rw !== 1'b0)      begin failures++; $display("FAIL rst_send_rw got=%b exp=0", send_rw); end
        if (init_done !== 1'b0)    begin failures++; $display("FAIL rst_init_done got=%b exp=0", init_done); end
        if (frame_done !== 1'b0)   begin failures++; $display("FAIL rst_frame_done got=%b exp=0", frame_done); end
        if (err !== 1'b0)          begin failures++; $display("FAIL rst_err got=%b exp=0", err); end
        @(negedge clk);
        rst = 1'b0;
        count_pwrup("pwrup");
        checks++;
        if ({send_rs, send_data} !== 9'h030) begin
            failures++;
            $display("FAIL first_xfer got=%h exp=030", {send_rs, send_data});
        end
    endtask

    task automatic test_init();
        logic [8:0] x, e;
        bit ok;
        do_write(6'h25, 8'h41);
        exp_q.push_back(9'h030);
        exp_q.push_back(9'h00C);
        exp_q.push_back(9'h001);
        exp_q.push_back(9'h006);
        push_line(0);
        for (int i = 0; i < 21; i++) begin
            get_xfer(x, ok);
            e = exp_q.pop_front();
            checks++;
            if (!ok || x !== e) begin
                failures++;
                $display("FAIL init_stream[%0d] got=%h exp=%h ok=%0d", i, x, e, ok);
                if (!ok) break;
            end
            $display("xfer init_stream[%0d] rs=%b data=%h", i, x[8], x[7:0]);
            if (i == 3 || i == 4) begin
                checks++;
                if (init_done !== (i == 4)) begin
                    failures++;
                    $display("FAIL init_done_at[%0d] got=%b exp=%b", i, init_done, (i == 4));
                end
            end
        end
        exp_q.delete();
    endtask

    task automatic test_frame_line2();
        logic [8:0] x, e;
        bit ok;
        int n = 0;
        for (int l = 1; l < 4; l++) push_line(l);
        for (int i = 0; i < 51; i++) begin
            get_xfer(x, ok);
            e = exp_q.pop_front();
            checks++;
            if (!ok || x !== e) begin
                failures++;
                $display("FAIL frame1[%0d] got=%h exp=%h ok=%0d", i, x, e, ok);
                if (!ok) break;
            end
            $display("xfer frame1[%0d] rs=%b data=%h", i, x[8], x[7:0]);
        end
        exp_q.delete();
        while (fd_count == 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks += 2;
        if (fd_count != 1) begin
            failures++;
            $display("FAIL frame_done_count got=%0d exp=1", fd_count);
        end
        if (fd_at.size() == 0 || fd_at[0] != 4 + 68) begin
            failures++;
            $display("FAIL frame_done_position got=%0d exp=72", (fd_at.size() == 0) ? -1 : fd_at[0]);
        end
    endtask

    task automatic test_update_during_transfer();
        logic [8:0] x, e;
        bit ok;
        push_line(0);
        for (int l = 1; l < 4; l++) push_line(l);
        for (int i = 0; i < 68; i++) begin
            get_xfer(x, ok);
            // Column 0 of line 0 has just been accepted: rewrite it while in COMPLETE.
            if (i == 1) do_write(6'h00, 8'h42);
            e = exp_q.pop_front();
            checks++;
            if (!ok || x !== e) begin
                failures++;
                $display("FAIL frame2[%0d] got=%h exp=%h ok=%0d", i, x, e, ok);
                if (!ok) break;
            end
            $display("xfer frame2[%0d] rs=%b data=%h", i, x[8], x[7:0]);
        end
        exp_q.delete();
        exp_q.push_back({1'b0, line_cmd[0]});
        exp_q.push_back({1'b1, model_mem[0]});
        for (int i = 0; i < 2; i++) begin
            get_xfer(x, ok);
            e = exp_q.pop_front();
            checks++;
            if (!ok || x !== e) begin
                failures++;
                $display("FAIL frame3[%0d] got=%h exp=%h ok=%0d", i, x, e, ok);
                if (!ok) break;
            end
            $display("xfer frame3[%0d] rs=%b data=%h", i, x[8], x[7:0]);
        end
        exp_q.delete();
        checks++;
        if (fd_count != 2) begin
            failures++;
            $display("FAIL frame_done_count2 got=%0d exp=2", fd_count);
        end
    endtask

    task automatic test_timeout();
        logic [8:0] x;
        bit ok;
        int n = 0;
        drv_mute = 1'b1;
        while (!send_en && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        n = 0;
        while (err !== 1'b1 && n < 1200) begin
            @(posedge clk);
            #1;
            n++;
        end
        // One ISSUE cycle plus 1000 ACCEPT cycles with send_en high.
        checks += 3;
        if (n < 1000 || n > 1001) begin
            failures++;
            $display("FAIL timeout_latency got=%0d exp=1000..1001", n);
        end
        if (send_en !== 1'b0) begin
            failures++;
            $display("FAIL timeout_send_en got=%b exp=0", send_en);
        end
        if (init_done !== 1'b0) begin
            failures++;
            $display("FAIL timeout_init_done got=%b exp=0", init_done);
        end
        count_pwrup("timeout_pwrup");
        drv_mute = 1'b0;
        get_xfer(x, ok);
        checks += 2;
        if (!ok || x !== 9'h030) begin
            failures++;
            $display("FAIL reinit_first got=%h exp=030 ok=%0d", x, ok);
        end
        $display("xfer reinit rs=%b data=%h", x[8], x[7:0]);
        if (err !== 1'b1) begin
            failures++;
            $display("FAIL err_sticky got=%b exp=1", err);
        end
    endtask

    task automatic test_reset_mid_transfer();
        logic [8:0] x, e;
        bit ok;
        int n = 0;
        while (!(send_en && send_rs) && n < 1500) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (!(send_en && send_rs)) begin
            failures++;
            $display("FAIL data_send_en_wait got=%b exp=1", send_en);
        end
        rst = 1'b1;
        #1;
        checks += 3;
        if (send_en !== 1'b0) begin
            failures++;
            $display("FAIL async_drop_send_en got=%b exp=0", send_en);
        end
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL rst_clears_err got=%b exp=0", err);
        end
        if (init_done !== 1'b0) begin
            failures++;
            $display("FAIL rst_clears_init_done got=%b exp=0", init_done);
        end
        for (int i = 0; i < 64; i++) model_mem[i] = 8'h20;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        count_pwrup("rerst_pwrup");
        exp_q.push_back(9'h030);
        exp_q.push_back(9'h00C);
        exp_q.push_back(9'h001);
        exp_q.push_back(9'h006);
        for (int l = 0; l < 4; l++) push_line(l);
        for (int i = 0; i < 72; i++) begin
            get_xfer(x, ok);
            e = exp_q.pop_front();
            checks++;
            if (!ok || x !== e) begin
                failures++;
                $display("FAIL after_rst[%0d] got=%h exp=%h ok=%0d", i, x, e, ok);
                if (!ok) break;
            end
            $display("xfer after_rst[%0d] rs=%b data=%h", i, x[8], x[7:0]);
        end
        exp_q.delete();
    endtask

    task automatic test_stability();
        checks++;
        if (stab_viol != 0) begin
            failures++;
            $display("FAIL send_stability violations got=%0d exp=0", stab_viol);
        end
    endtask

    initial begin
        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        line_cmd[0] = 8'h80;
        line_cmd[1] = 8'h90;
        line_cmd[2] = 8'h88;
        line_cmd[3] = 8'h98;
        for (int i = 0; i < 64; i++) model_mem[i] = 8'h20;
        test_reset();
        test_init();
        test_frame_line2();
        test_update_during_transfer();
        test_timeout();
        test_reset_mid_transfer();
        test_stability();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
